alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// FIFO buffering ALU results {opcode, result, negative flag} with a derived zero flag.
// Define ALU_FIFO_DROP_CNT_EN to add the saturating drop_cnt port counting refused writes.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [1:0]                 OP,
  input  logic [4:0]                 R,
  input  logic                       Neg,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [4:0]                 out_r,
  output logic                       out_neg,
  output logic                       out_zero,
`ifdef ALU_FIFO_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] r;
    logic       neg;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               active;
  logic               do_write;
  logic               do_read;
  entry_t             head;
  entry_t             wr_entry;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  // The first edge after reset release is inert; active gates both handshakes.
  assign do_write = in_valid && in_ready && active;
  assign do_read  = out_valid && out_ready && active;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    wr_entry     = '0;
    wr_entry.op  = OP;
    wr_entry.r   = R;
    // The ALU leaves Neg stale for anything but SUB.
    wr_entry.neg = (OP == OP_SUB) ? Neg : 1'b0;
  end

  // NOTE: storage has no reset; clearing the pointers and count invalidates all entries.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  assign head     = mem[rd_ptr];
  assign out_op   = head.op;
  assign out_r    = head.r;
  assign out_neg  = head.neg;
  assign out_zero = (head.r == 5'd0);

endmodule
